ras_ckpt: RTL and testbench

Checkpointed, circular-buffer return address stack for the fetch stage, replacing the shift-register RAS. Each fetched jump is classified by its link registers into push, pop or pop-then-push. Every state change is a pointer move plus at most one entry write; nothing shifts. The block exports a compact snapshot (top pointer, occupancy, top entry) to attach to each predicted control-flow instruction, and restores from that snapshot in one cycle on a misprediction. It also reports occupancy and overflow/underflow events for the performance counters.

---
 rtl/ras_ckpt.sv | 132 +++++++++++++
 tb/tb_ras_ckpt.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ckpt.sv
// Checkpointed circular return address stack: push/pop/pop-then-push with one-cycle snapshot restore.
// Latency: prediction outputs are combinational in the request cycle; state updates at the next clk_i edge.
// Backpressure: none; accepts one classified request every cycle, flush and restore drop a same-cycle request.
module ras_ckpt #(
  parameter  int XLEN     = 32,
  parameter  int RAS_SIZE = 16,
  localparam int PTR_W    = $clog2(RAS_SIZE),
  localparam int CNT_W    = $clog2(RAS_SIZE + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  input  logic             j_type_i,
  input  logic             jr_type_i,
  input  logic [4:0]       rd_addr_i,
  input  logic [4:0]       r1_addr_i,
  input  logic [XLEN-1:0]  return_addr_i,
  input  logic             flush_i,
  input  logic             restore_valid_i,
  input  logic [PTR_W-1:0] restore_ptr_i,
  input  logic [CNT_W-1:0] restore_cnt_i,
  input  logic [XLEN-1:0]  restore_data_i,
  output logic             pop_valid_o,
  output logic [XLEN-1:0]  pop_addr_o,
  output logic [PTR_W-1:0] ckpt_ptr_o,
  output logic [CNT_W-1:0] ckpt_cnt_o,
  output logic [XLEN-1:0]  ckpt_data_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_BOTH = 2'd3
  } ras_op_e;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_SIZE);

  logic [XLEN-1:0]  mem [RAS_SIZE];
  logic [PTR_W-1:0] tos;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] tos_inc;
  logic [PTR_W-1:0] tos_dec;
  logic             link_rd;
  logic             link_r1;
  logic             is_full;
  logic             is_empty;
  logic             req_act;
  ras_op_e          op;

  assign link_rd  = (rd_addr_i == 5'd1) || (rd_addr_i == 5'd5);
  assign link_r1  = (r1_addr_i == 5'd1) || (r1_addr_i == 5'd5);
  assign is_full  = (cnt == CNT_FULL);
  assign is_empty = (cnt == '0);
  assign tos_inc  = tos + PTR_W'(1);
  assign tos_dec  = tos - PTR_W'(1);
  // Reset, flush and restore all take precedence over the fetched request.
  assign req_act  = req_valid_i && !rst_i && !flush_i && !restore_valid_i;

  // Snapshot and prediction read the pre-update top of stack.
  assign ckpt_ptr_o  = tos;
  assign ckpt_cnt_o  = cnt;
  assign ckpt_data_o = mem[tos];
  assign pop_addr_o  = mem[tos];

  // Classify the jump by its link registers; JAL takes precedence if both type bits are set.
  always_comb begin
    op = OP_NONE;
    if (req_act) begin
      if (j_type_i) begin
        if (link_rd) op = OP_PUSH;
      end else if (jr_type_i) begin
        if (link_rd && !link_r1)      op = OP_PUSH;
        else if (!link_rd && link_r1) op = OP_POP;
        else if (link_rd && link_r1)  op = (rd_addr_i == r1_addr_i) ? OP_PUSH : OP_BOTH;
      end
    end
  end

  // Prediction and performance-event outputs for the current request.
  always_comb begin
    pop_valid_o = 1'b0;
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    case (op)
      OP_PUSH: overflow_o = is_full;
      OP_POP, OP_BOTH: begin
        pop_valid_o = !is_empty;
        underflow_o = is_empty;
      end
      default: ;
    endcase
  end

  // Pointer, occupancy and single-entry write; nothing ever shifts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tos <= '0;
      cnt <= '0;
      mem <= '{default: '0};
    end else if (flush_i) begin
      tos <= '0;
      cnt <= '0;
    end else if (restore_valid_i) begin
      tos                <= restore_ptr_i;
      cnt                <= restore_cnt_i;
      mem[restore_ptr_i] <= restore_data_i;
    end else begin
      case (op)
        OP_PUSH: begin
          tos          <= tos_inc;
          mem[tos_inc] <= return_addr_i;
          if (!is_full) cnt <= cnt + CNT_W'(1);
        end
        OP_POP: begin
          if (!is_empty) begin
            tos <= tos_dec;
            cnt <= cnt - CNT_W'(1);
          end
        end
        OP_BOTH: begin
          mem[tos] <= return_addr_i;
          if (is_empty) cnt <= CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ras_ckpt.sv
// Bench for ras_ckpt with a 4-entry stack against an array-based reference model.
// Inputs are driven on the falling edge; outputs are compared 1 time unit later.
// Directed scenarios first, then randomized request/flush/restore/reset traffic.
module tb_ras_ckpt;

  localparam int XL = 32;
  localparam int RS = 4;
  localparam int PW = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, req_valid, j_type, jr_type, flush, restore_valid;
  logic [4:0]    rd_addr, r1_addr;
  logic [XL-1:0] return_addr, restore_data;
  logic [PW-1:0] restore_ptr;
  logic [CW-1:0] restore_cnt;
  logic          pop_valid, overflow, underflow;
  logic [XL-1:0] pop_addr, ckpt_data;
  logic [PW-1:0] ckpt_ptr;
  logic [CW-1:0] ckpt_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [XL-1:0] m_mem [RS];
  int            m_tos, m_cnt;

  always #5 clk = ~clk;

  ras_ckpt #(.XLEN(XL), .RAS_SIZE(RS)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .j_type_i(j_type),
    .jr_type_i(jr_type), .rd_addr_i(rd_addr), .r1_addr_i(r1_addr),
    .return_addr_i(return_addr), .flush_i(flush), .restore_valid_i(restore_valid),
    .restore_ptr_i(restore_ptr), .restore_cnt_i(restore_cnt), .restore_data_i(restore_data),
    .pop_valid_o(pop_valid), .pop_addr_o(pop_addr), .ckpt_ptr_o(ckpt_ptr),
    .ckpt_cnt_o(ckpt_cnt), .ckpt_data_o(ckpt_data), .overflow_o(overflow),
    .underflow_o(underflow)
  );

  // Snapshot occupancy above the stack depth must never be presented.
  always @(posedge clk) begin
    if (restore_valid) assert (restore_cnt <= 3'(RS)) else $error("illegal restore_cnt %0d", restore_cnt);
  end

  task automatic chk(input string tag, input logic [XL-1:0] got, input logic [XL-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // 0 none, 1 push, 2 pop, 3 pop-then-push
  function automatic int classify(input logic j, input logic jr, input logic [4:0] rd, input logic [4:0] r1);
    if (j) return is_link(rd) ? 1 : 0;
    if (jr) begin
      if (is_link(rd) && !is_link(r1)) return 1;
      if (!is_link(rd) && is_link(r1)) return 2;
      if (is_link(rd) && is_link(r1)) return (rd == r1) ? 1 : 3;
    end
    return 0;
  endfunction

  task automatic clear_inputs();
    rst = 0; req_valid = 0; j_type = 0; jr_type = 0; rd_addr = 0; r1_addr = 0;
    return_addr = 0; flush = 0; restore_valid = 0; restore_ptr = 0; restore_cnt = 0;
    restore_data = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < RS; i++) m_mem[i] = '0;
    m_tos = 0;
    m_cnt = 0;
  endtask

  // One cycle: drive, compare against the model, clock, update the model.
  task automatic cyc(input logic i_rst, input logic i_fl, input logic i_rs,
                     input logic [PW-1:0] i_rp, input logic [CW-1:0] i_rc, input logic [XL-1:0] i_rd,
                     input logic i_rv, input logic i_j, input logic i_jr,
                     input logic [4:0] i_rdr, input logic [4:0] i_r1, input logic [XL-1:0] i_ra);
    int op;
    @(negedge clk);
    rst = i_rst; flush = i_fl; restore_valid = i_rs; restore_ptr = i_rp; restore_cnt = i_rc;
    restore_data = i_rd; req_valid = i_rv; j_type = i_j; jr_type = i_jr;
    rd_addr = i_rdr; r1_addr = i_r1; return_addr = i_ra;
    #1;
    op = (i_rv && !i_rst && !i_fl && !i_rs) ? classify(i_j, i_jr, i_rdr, i_r1) : 0;
    chk("ckpt_ptr", XL'(ckpt_ptr), XL'(m_tos));
    chk("ckpt_cnt", XL'(ckpt_cnt), XL'(m_cnt));
    chk("ckpt_data", ckpt_data, m_mem[m_tos]);
    chk("pop_valid", XL'(pop_valid), XL'((op >= 2) && (m_cnt > 0)));
    chk("underflow", XL'(underflow), XL'((op >= 2) && (m_cnt == 0)));
    chk("overflow", XL'(overflow), XL'((op == 1) && (m_cnt == RS)));
    if ((op >= 2) && (m_cnt > 0)) chk("pop_addr", pop_addr, m_mem[m_tos]);
    @(posedge clk);
    if (i_rst) model_reset();
    else if (i_fl) begin
      m_tos = 0;
      m_cnt = 0;
    end else if (i_rs) begin
      m_tos = int'(i_rp);
      m_cnt = int'(i_rc);
      m_mem[m_tos] = i_rd;
    end else begin
      case (op)
        1: begin
          m_tos = (m_tos + 1) % RS;
          m_mem[m_tos] = i_ra;
          if (m_cnt < RS) m_cnt++;
        end
        2: if (m_cnt > 0) begin
          m_tos = (m_tos + RS - 1) % RS;
          m_cnt--;
        end
        3: begin
          m_mem[m_tos] = i_ra;
          if (m_cnt == 0) m_cnt = 1;
        end
        default: ;
      endcase
    end
    #1;
    clear_inputs();
  endtask

  task automatic req(input logic j, input logic jr, input logic [4:0] rd, input logic [4:0] r1, input logic [XL-1:0] ra);
    cyc(0, 0, 0, '0, '0, '0, 1, j, jr, rd, r1, ra);
  endtask
  task automatic push(input logic [XL-1:0] ra); req(1, 0, 5'd1, 5'd0, ra); endtask
  task automatic pop();                         req(0, 1, 5'd0, 5'd1, '0); endtask
  task automatic do_reset();                    cyc(1, 0, 0, '0, '0, '0, 0, 0, 0, 5'd0, 5'd0, '0); endtask

  function automatic logic [4:0] rand_reg();
    logic [4:0] r;
    case ($urandom_range(0, 4))
      0: r = 5'd0;
      1: r = 5'd1;
      2: r = 5'd5;
      3: r = 5'd6;
      default: r = 5'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    int kind;
    logic [XL-1:0] addr;
    clear_inputs();
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Underflow on an empty stack
    pop();

    // Overflow and wrap with a 4-entry stack
    push(32'h100); push(32'h200); push(32'h300); push(32'h400); push(32'h500);
    pop(); pop(); pop(); pop(); pop();

    // Pop-then-push on a one-entry stack
    do_reset();
    push(32'h100);
    req(0, 1, 5'd5, 5'd1, 32'h80);
    pop();

    // Snapshot, wrong path, restore
    do_reset();
    push(32'h100);
    @(negedge clk); #1;
    chk("snap_ptr", XL'(ckpt_ptr), 32'd1);
    chk("snap_cnt", XL'(ckpt_cnt), 32'd1);
    chk("snap_data", ckpt_data, 32'h100);
    pop();
    push(32'hDEAD);
    cyc(0, 0, 1, 2'd1, 3'd1, 32'h100, 0, 0, 0, 5'd0, 5'd0, '0);
    @(negedge clk); #1;
    chk("restored_top", pop_addr, 32'h100);
    pop();

    // Flush + restore + push in one cycle, then the same with reset
    push(32'h111); push(32'h222);
    cyc(0, 1, 1, 2'd3, 3'd2, 32'hBAD, 1, 1, 0, 5'd1, 5'd0, 32'hBEEF);
    push(32'h333);
    cyc(1, 1, 1, 2'd2, 3'd3, 32'hBAD, 1, 1, 0, 5'd1, 5'd0, 32'hBEEF);
    @(negedge clk); #1;
    chk("rst_ptr", XL'(ckpt_ptr), 32'd0);
    chk("rst_cnt", XL'(ckpt_cnt), 32'd0);
    chk("rst_data", ckpt_data, 32'd0);

    // Same-register JALR pushes; non-link jumps do nothing
    req(0, 1, 5'd1, 5'd1, 32'h44);
    req(1, 0, 5'd0, 5'd1, 32'h55);
    req(0, 1, 5'd0, 5'd6, 32'h66);
    pop();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      kind = $urandom_range(0, 99);
      addr = $urandom;
      if (kind < 2)
        do_reset();
      else if (kind < 5)
        cyc(0, 1, $urandom_range(0, 1), 2'($urandom), 3'($urandom_range(0, RS)), addr,
            1, 0, 1, rand_reg(), rand_reg(), addr);
      else if (kind < 10)
        cyc(0, 0, 1, 2'($urandom), 3'($urandom_range(0, RS)), addr,
            $urandom_range(0, 1), 1, 0, 5'd1, 5'd0, ~addr);
      else if (kind < 35)
        push(addr);
      else if (kind < 60)
        pop();
      else if (kind < 70)
        req(0, 1, 5'd1, 5'd5, addr);
      else
        req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_reg(), rand_reg(), addr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
